// File: rtl/acc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Owns PC, IR, halt/fault status and the memory req/ack handshake with its timeout.
module acc_seq_ctrl #(
    parameter logic [3:0] RESET_PC = 4'h0,
    parameter int         TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    output logic       mem_req,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic       acc_zero,
    output logic       acc_update,
    output logic [1:0] x_sel,
    output logic [1:0] alu_op,
    output logic [3:0] imm,
    output logic [3:0] pc,
    output logic [7:0] ir,
    output logic       halted,
    output logic       fault,
    output logic       illegal
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_READ,
        ST_WRITE,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] XS_MEM = 2'b00;
    localparam logic [1:0] XS_ALU = 2'b01;
    localparam logic [1:0] XS_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Counter holds the number of wait cycles already spent on the current request.
    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t           state_reg, state_next;
    logic [3:0]       pc_reg, pc_next;
    logic [7:0]       ir_reg, ir_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fault_reg, fault_next;

    logic [3:0] opcode;
    logic [3:0] operand;
    logic       bus_active;
    logic       timeout_hit;
    logic       opcode_undef;

    assign opcode       = ir_reg[7:4];
    assign operand      = ir_reg[3:0];
    assign bus_active   = (state_reg == ST_FETCH) || (state_reg == ST_READ) ||
                          (state_reg == ST_WRITE);
    assign opcode_undef = (opcode >= 4'h9) && (opcode <= 4'hE);
    // An ack in the final wait cycle still completes the request normally.
    assign timeout_hit  = TO_EN && bus_active && !mem_ack && (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        fault_next = fault_reg;
        cnt_next   = '0;

        case (state_reg)
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc_reg + 4'd1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: state_next = ST_READ;
                    OP_STA: state_next = ST_WRITE;
                    OP_HLT: state_next = ST_HALT;
                    OP_JMP: begin
                        pc_next    = operand;
                        state_next = ST_FETCH;
                    end
                    OP_JZ: begin
                        if (acc_zero) begin
                            pc_next = operand;
                        end
                        state_next = ST_FETCH;
                    end
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_READ, ST_WRITE: begin
                if (mem_ack) begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase

        if (timeout_hit) begin
            state_next = ST_HALT;
            fault_next = 1'b1;
        end

        if (TO_EN && bus_active && !mem_ack && (state_next == state_reg)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_PC;
            ir_reg    <= 8'h00;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            cnt_reg   <= cnt_next;
            fault_reg <= fault_next;
        end
    end

    // Strobes are forced low while rst is high so a pending ack cannot load the accumulator.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_reg;
        acc_update = 1'b0;
        x_sel      = XS_MEM;
        alu_op     = ALU_PASS;
        illegal    = 1'b0;

        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_reg;
                end
                ST_DECODE: begin
                    if (opcode == OP_LDI) begin
                        acc_update = 1'b1;
                        x_sel      = XS_IMM;
                    end
                    illegal = opcode_undef;
                end
                ST_READ: begin
                    mem_req  = 1'b1;
                    mem_addr = operand;
                    if (mem_ack) begin
                        acc_update = 1'b1;
                        case (opcode)
                            OP_ADD: begin
                                x_sel  = XS_ALU;
                                alu_op = ALU_ADD;
                            end
                            OP_SUB: begin
                                x_sel  = XS_ALU;
                                alu_op = ALU_SUB;
                            end
                            OP_AND: begin
                                x_sel  = XS_ALU;
                                alu_op = ALU_AND;
                            end
                            default: x_sel = XS_MEM;
                        endcase
                    end
                end
                ST_WRITE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = operand;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign imm    = ir_reg[3:0];
    assign pc     = pc_reg;
    assign ir     = ir_reg;
    assign halted = (state_reg == ST_HALT);
    assign fault  = fault_reg;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: memory/accumulator environment plus an instruction-level ISA
// model that predicts bus transactions, final accumulator, PC and cycle counts.
module tb_acc_seq_ctrl;

    localparam int         TIMEOUT  = 15;
    localparam logic [3:0] RESET_PC = 4'h0;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_req, mem_we, mem_ack, acc_zero;
    logic [3:0] mem_addr, imm, pc;
    logic [7:0] mem_rdata, ir;
    logic       acc_update, halted, fault, illegal;
    logic [1:0] x_sel, alu_op;

    always #5 clk = ~clk;

    acc_seq_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .acc_zero(acc_zero),
        .acc_update(acc_update), .x_sel(x_sel), .alu_op(alu_op), .imm(imm), .pc(pc),
        .ir(ir), .halted(halted), .fault(fault), .illegal(illegal)
    );

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } txn_t;

    logic [7:0] mem [16];
    logic [7:0] acc;
    txn_t       obs_q[$];
    txn_t       exp_q[$];
    int         upd_cyc_q[$];
    int         ill_cyc_q[$];
    int         cyc, waits_total, wait_cnt, cur_wait, fixed_wait, halt_cyc, wr_cyc;
    bit         rand_wait, ack_on, force_ack, unstable, in_req;
    logic [3:0] req_addr;
    logic       req_we;

    int         exp_ninstr, exp_nmem, exp_upd, exp_ill;
    bit         exp_halt;
    logic [7:0] exp_acc;
    logic [3:0] exp_pc;

    int nvec  = 0;
    int nfail = 0;

    // One clock cycle: respond at the negedge, sample, then commit datapath/memory at posedge.
    task automatic step();
        logic       d_upd, d_ack, d_we, d_req;
        logic [1:0] d_xsel, d_alu;
        logic [3:0] d_imm, d_addr;
        logic [7:0] d_rdata;
        acc_zero  = (acc == 8'h00);
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        #1;
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (mem_req && !rst) begin
            if (!in_req) begin
                in_req   = 1'b1;
                req_addr = mem_addr;
                req_we   = mem_we;
            end else if (mem_addr !== req_addr || mem_we !== req_we) begin
                unstable = 1'b1;
            end
            if (ack_on && wait_cnt >= cur_wait) begin
                mem_ack = 1'b1;
                if (!mem_we) mem_rdata = mem[mem_addr];
            end else begin
                wait_cnt++;
                waits_total++;
            end
        end
        #1;
        d_req   = mem_req;
        d_ack   = mem_ack && mem_req;
        d_we    = mem_we;
        d_addr  = mem_addr;
        d_upd   = acc_update;
        d_xsel  = x_sel;
        d_alu   = alu_op;
        d_imm   = imm;
        d_rdata = mem_rdata;
        if (acc_update) upd_cyc_q.push_back(cyc);
        if (illegal) ill_cyc_q.push_back(cyc);
        if (halted && halt_cyc < 0) halt_cyc = cyc;
        if (d_ack) begin
            obs_q.push_back(txn_t'{d_we, d_addr, d_we ? acc : d_rdata});
            if (d_we) wr_cyc = cyc;
        end
        @(posedge clk);
        if (d_ack && d_we && !rst) mem[d_addr] = acc;
        if (rst) begin
            acc = 8'h00;
        end else if (d_upd) begin
            case (d_xsel)
                2'b00: acc = d_rdata;
                2'b01: begin
                    case (d_alu)
                        2'b00:   acc = acc + d_rdata;
                        2'b01:   acc = acc - d_rdata;
                        2'b10:   acc = acc & d_rdata;
                        default: acc = d_rdata;
                    endcase
                end
                2'b10:   acc = {4'h0, d_imm};
                default: acc = acc;
            endcase
        end
        if (rst || d_ack || !d_req) begin
            in_req   = 1'b0;
            wait_cnt = 0;
        end
        if (d_ack) cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
        cyc++;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        upd_cyc_q.delete();
        ill_cyc_q.delete();
        cyc         = 0;
        waits_total = 0;
        wait_cnt    = 0;
        in_req      = 1'b0;
        unstable    = 1'b0;
        halt_cyc    = -1;
        wr_cyc      = -1;
        cur_wait    = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic run_until_halt(input int budget, output bit expired);
        int n = 0;
        while (halt_cyc < 0 && n < budget) begin
            step();
            n++;
        end
        expired = (halt_cyc < 0);
    endtask

    // Instruction-level interpreter of the ISA over a private copy of memory.
    task automatic model_run(input int max_instr);
        logic [7:0] m [16];
        logic [3:0] p, a;
        logic [7:0] r, ins;
        m = mem;
        p = RESET_PC;
        r = 8'h00;
        exp_q.delete();
        exp_ninstr = 0; exp_nmem = 0; exp_upd = 0; exp_ill = 0; exp_halt = 1'b0;
        for (int n = 0; n < max_instr && !exp_halt; n++) begin
            ins = m[p];
            exp_q.push_back(txn_t'{1'b0, p, ins});
            p = p + 4'd1;
            a = ins[3:0];
            exp_ninstr++;
            case (ins[7:4])
                4'h0: ;
                4'h1, 4'h2, 4'h3, 4'h4: begin
                    exp_q.push_back(txn_t'{1'b0, a, m[a]});
                    exp_nmem++;
                    exp_upd++;
                    if (ins[7:4] == 4'h1) r = m[a];
                    else if (ins[7:4] == 4'h2) r = r + m[a];
                    else if (ins[7:4] == 4'h3) r = r - m[a];
                    else r = r & m[a];
                end
                4'h5: begin
                    exp_q.push_back(txn_t'{1'b1, a, r});
                    m[a] = r;
                    exp_nmem++;
                end
                4'h6: p = a;
                4'h7: if (r == 8'h00) p = a;
                4'h8: begin
                    r = {4'h0, a};
                    exp_upd++;
                end
                4'hF: exp_halt = 1'b1;
                default: exp_ill++;
            endcase
        end
        exp_acc = r;
        exp_pc  = p;
    endtask

    task automatic load_prog(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) mem[i] = fill;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        nvec++;
        if ({mem_req, acc_update, illegal, halted, fault} !== 5'b0) begin
            nfail++;
            $display("FAIL reset_strobes: got %b expected 00000", {mem_req, acc_update, illegal, halted, fault});
        end
        nvec++;
        if (pc !== RESET_PC || ir !== 8'h00) begin
            nfail++;
            $display("FAIL reset_pc_ir: got pc=%h ir=%h expected pc=%h ir=00", pc, ir, RESET_PC);
        end
        rst = 1'b0;
        clear_obs();
        #1;
        nvec++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC || mem_we !== 1'b0) begin
            nfail++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h we=%b expected 1 %h 0", mem_req, mem_addr, mem_we, RESET_PC);
        end
        $display("test_reset done");
    endtask

    task automatic test_program1();
        bit expired;
        load_prog(8'h00);
        mem[0] = 8'h84; mem[1] = 8'h2A; mem[2] = 8'h5B; mem[3] = 8'hF0; mem[10] = 8'h03;
        rand_wait = 1'b0; fixed_wait = 0; ack_on = 1'b1;
        do_reset();
        run_until_halt(100, expired);
        nvec++;
        if (expired) begin nfail++; $display("FAIL prog1_halt: got no halt expected halt within 100 cycles"); end
        nvec++;
        if (upd_cyc_q.size() != 2 || upd_cyc_q[0] != 1 || upd_cyc_q[1] != 4) begin
            nfail++;
            $display("FAIL prog1_upd_cycles: got n=%0d first=%0d expected cycles 2 and 5", upd_cyc_q.size(),
                     upd_cyc_q.size() > 0 ? upd_cyc_q[0] + 1 : -1);
        end
        nvec++;
        if (wr_cyc != 7 || mem[11] !== 8'h07) begin
            nfail++;
            $display("FAIL prog1_write: got cycle=%0d data=%h expected cycle 8 data 07", wr_cyc + 1, mem[11]);
        end
        nvec++;
        if (halt_cyc != 10 || pc !== 4'h4) begin
            nfail++;
            $display("FAIL prog1_halt_state: got cycle=%0d pc=%h expected cycle 11 pc 4", halt_cyc + 1, pc);
        end
        $display("test_program1 done: halt cycle %0d", halt_cyc + 1);
    endtask

    task automatic test_jz(input logic [7:0] ldi, input logic [3:0] exp_fetch);
        bit expired;
        load_prog(8'hF0);
        mem[0] = ldi; mem[1] = 8'h79;
        rand_wait = 1'b0; fixed_wait = 0; ack_on = 1'b1;
        do_reset();
        run_until_halt(50, expired);
        nvec++;
        if (expired || obs_q.size() < 3 || obs_q[2].addr !== exp_fetch) begin
            nfail++;
            $display("FAIL jz_target: got fetch addr=%h expected %h (ldi %h)",
                     obs_q.size() >= 3 ? obs_q[2].addr : 4'hx, exp_fetch, ldi);
        end
        $display("test_jz done: ldi=%h next fetch expected %h", ldi, exp_fetch);
    endtask

    task automatic test_wait_states();
        bit expired;
        logic [7:0] val;
        val = 8'($urandom);
        load_prog(8'h00);
        mem[0] = 8'h15; mem[1] = 8'hF0; mem[5] = val;
        rand_wait = 1'b0; fixed_wait = 3; ack_on = 1'b1;
        do_reset();
        run_until_halt(100, expired);
        nvec++;
        if (expired || halt_cyc != 14) begin
            nfail++;
            $display("FAIL wait_latency: got halt cycle=%0d expected 14 (LDA 9 + HLT 5)", halt_cyc);
        end
        nvec++;
        if (upd_cyc_q.size() != 1 || upd_cyc_q[0] != 8) begin
            nfail++;
            $display("FAIL wait_upd_once: got n=%0d expected one pulse at cycle 9", upd_cyc_q.size());
        end
        nvec++;
        if (unstable || acc !== val) begin
            nfail++;
            $display("FAIL wait_stable_acc: got unstable=%b acc=%h expected 0 %h", unstable, acc, val);
        end
        $display("test_wait_states done: acc=%h", acc);
    endtask

    task automatic test_timeout();
        bit expired;
        load_prog(8'hF0);
        rand_wait = 1'b0; fixed_wait = 0; ack_on = 1'b0;
        do_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        nvec++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_early: got fault=%b halted=%b after %0d waits expected 0 0", fault, halted, TIMEOUT - 1);
        end
        step();
        nvec++;
        if (fault !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_fault: got fault=%b halted=%b req=%b expected 1 1 0", fault, halted, mem_req);
        end
        nvec++;
        if (pc !== RESET_PC || ir !== 8'h00 || obs_q.size() != 0) begin
            nfail++;
            $display("FAIL timeout_noupdate: got pc=%h ir=%h txns=%0d expected %h 00 0", pc, ir, obs_q.size(), RESET_PC);
        end
        ack_on = 1'b1;
        do_reset();
        #1;
        nvec++;
        if (fault !== 1'b0 || pc !== 4'h0 || mem_req !== 1'b1) begin
            nfail++;
            $display("FAIL timeout_recover: got fault=%b pc=%h req=%b expected 0 0 1", fault, pc, mem_req);
        end
        run_until_halt(50, expired);
        nvec++;
        if (expired || halt_cyc != 2 || fault !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_resume: got halt cycle=%0d fault=%b expected 2 0", halt_cyc, fault);
        end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_read();
        bit expired;
        load_prog(8'h00);
        mem[0] = 8'h15; mem[1] = 8'hF0; mem[5] = 8'hA5;
        rand_wait = 1'b0; fixed_wait = 3; ack_on = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        upd_cyc_q.delete();
        rst = 1'b1;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        rst = 1'b0;
        nvec++;
        if (upd_cyc_q.size() != 0 || acc !== 8'h00) begin
            nfail++;
            $display("FAIL midread_no_update: got pulses=%0d acc=%h expected 0 00", upd_cyc_q.size(), acc);
        end
        clear_obs();
        #1;
        nvec++;
        if (pc !== RESET_PC || mem_req !== 1'b1 || mem_addr !== RESET_PC || mem_we !== 1'b0) begin
            nfail++;
            $display("FAIL midread_refetch: got pc=%h req=%b addr=%h expected %h 1 %h", pc, mem_req, mem_addr, RESET_PC, RESET_PC);
        end
        model_run(10);
        run_until_halt(100, expired);
        nvec++;
        if (expired || obs_q.size() != exp_q.size() || acc !== exp_acc || upd_cyc_q.size() != exp_upd) begin
            nfail++;
            $display("FAIL midread_rerun: got txns=%0d acc=%h upd=%0d expected %0d %h %0d",
                     obs_q.size(), acc, upd_cyc_q.size(), exp_q.size(), exp_acc, exp_upd);
        end
        $display("test_reset_mid_read done");
    endtask

    task automatic test_wrap_illegal();
        bit expired;
        load_prog(8'h00);
        mem[0] = 8'h7D; mem[1] = 8'hF0; mem[13] = 8'h81; mem[14] = 8'h6F; mem[15] = 8'h90;
        rand_wait = 1'b0; fixed_wait = 0; ack_on = 1'b1;
        do_reset();
        model_run(20);
        run_until_halt(100, expired);
        nvec++;
        if (expired || ill_cyc_q.size() != 1 || exp_ill != 1) begin
            nfail++;
            $display("FAIL wrap_illegal_pulse: got %0d illegal cycles expected 1", ill_cyc_q.size());
        end
        nvec++;
        if (obs_q.size() != exp_q.size() || obs_q.size() < 5 || obs_q[4].addr !== 4'h0 || pc !== exp_pc) begin
            nfail++;
            $display("FAIL wrap_pc: got txns=%0d pc=%h expected txns=%0d pc=%h, fetch after F at 0",
                     obs_q.size(), pc, exp_q.size(), exp_pc);
        end
        $display("test_wrap_illegal done: pc=%h", pc);
    endtask

    task automatic test_random_programs(input int nprog);
        bit expired;
        int tries;
        int mism;
        for (int k = 0; k < nprog; k++) begin
            tries = 0;
            do begin
                for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
                model_run(40);
                tries++;
            end while (!exp_halt && tries < 200);
            if (!exp_halt) begin
                mem[0] = 8'hF0;
                model_run(40);
            end
            rand_wait = 1'b1; ack_on = 1'b1;
            do_reset();
            run_until_halt(600, expired);
            mism = 0;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
                if (obs_q[i] !== exp_q[i]) mism++;
            nvec++;
            if (expired || obs_q.size() != exp_q.size() || mism != 0) begin
                nfail++;
                $display("FAIL rand_txns[%0d]: got %0d txns %0d differing expected %0d txns", k, obs_q.size(), mism, exp_q.size());
            end
            nvec++;
            if (acc !== exp_acc || pc !== exp_pc || fault !== 1'b0) begin
                nfail++;
                $display("FAIL rand_state[%0d]: got acc=%h pc=%h fault=%b expected %h %h 0", k, acc, pc, fault, exp_acc, exp_pc);
            end
            nvec++;
            if (halt_cyc != 2 * exp_ninstr + exp_nmem + waits_total) begin
                nfail++;
                $display("FAIL rand_latency[%0d]: got %0d cycles expected %0d", k, halt_cyc, 2 * exp_ninstr + exp_nmem + waits_total);
            end
            nvec++;
            if (upd_cyc_q.size() != exp_upd || ill_cyc_q.size() != exp_ill || unstable) begin
                nfail++;
                $display("FAIL rand_strobes[%0d]: got upd=%0d ill=%0d unstable=%b expected %0d %0d 0",
                         k, upd_cyc_q.size(), ill_cyc_q.size(), unstable, exp_upd, exp_ill);
            end
            $display("program %0d: %0d instr, %0d waits, acc=%h", k, exp_ninstr, waits_total, acc);
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; acc_zero = 1'b1; acc = 8'h00;
        force_ack = 1'b0; ack_on = 1'b1; rand_wait = 1'b0; fixed_wait = 0;
        load_prog(8'h00);
        clear_obs();
        @(negedge clk);
        test_reset();
        test_program1();
        test_jz(8'h80, 4'h9);
        test_jz(8'h81, 4'h2);
        test_wait_states();
        test_timeout();
        test_reset_mid_read();
        test_wrap_illegal();
        test_random_programs(8);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
